// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch core.
// States, BCD digit type and decade maximum.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_counter_if.sv
// stopwatch_counter_if: button inputs and display outputs of the stopwatch.
// Lap signals exist only when STOPWATCH_LAP_EN is defined.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic start_stop;
    logic clear;
    bcd_t dig0;
    bcd_t dig1;
    bcd_t dig2;
    bcd_t dig3;
    logic running;
    logic wrap;
`ifdef STOPWATCH_LAP_EN
    logic lap;
    logic lap_active;

    modport master (
        output start_stop, clear, lap,
        input  dig0, dig1, dig2, dig3, running, wrap, lap_active
    );
    modport slave (
        input  start_stop, clear, lap,
        output dig0, dig1, dig2, dig3, running, wrap, lap_active
    );
`else
    modport master (
        output start_stop, clear,
        input  dig0, dig1, dig2, dig3, running, wrap
    );
    modport slave (
        input  start_stop, clear,
        output dig0, dig1, dig2, dig3, running, wrap
    );
`endif

endinterface

// File: rtl/bcd_digit_cnt.sv
// bcd_digit_cnt: one decade of the ripple-carry BCD chain.
// Counts 0..i_max, carries combinationally when incremented at i_max.
module bcd_digit_cnt
    import stopwatch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    input  bcd_t i_max,
    output bcd_t o_digit,
    output logic o_carry
);

    bcd_t r_digit;

    assign o_carry = i_inc && (r_digit == i_max);
    assign o_digit = r_digit;

    // Digit register: clear has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= '0;
        end else if (i_clr) begin
            r_digit <= '0;
        end else if (o_carry) begin
            r_digit <= '0;
        end else if (i_inc) begin
            r_digit <= r_digit + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: prescaler, run-control FSM and SS.CC BCD chain.
// Optional lap freeze enabled by defining STOPWATCH_LAP_EN.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV   = 1000000,
    parameter int SEC_LIMIT = 60
) (
    input  logic clk,
    input  logic rst_n,
    stopwatch_counter_if.slave bus
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
    localparam bcd_t D3_MAX = 4'(SEC_LIMIT / 10 - 1);

    sw_state_t r_state;
    sw_state_t w_next;
    logic r_ss_q;
    logic r_clr_q;
    logic r_running;
    logic r_wrap;
    logic [PW-1:0] r_presc;
    logic w_ss_ev;
    logic w_clr_ev;
    logic w_tick;
    bcd_t w_d0, w_d1, w_d2, w_d3;
    logic w_c0, w_c1, w_c2, w_c3;

    assign w_ss_ev  = bus.start_stop & ~r_ss_q;
    assign w_clr_ev = bus.clear & ~r_clr_q;
    assign w_tick   = (r_state == RUN) && (r_presc == PMAX);

    // Button history; starts high so a held button gives no edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_q  <= 1'b1;
            r_clr_q <= 1'b1;
        end else begin
            r_ss_q  <= bus.start_stop;
            r_clr_q <= bus.clear;
        end
    end

    // Run-control state and registered running flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_running <= (w_next == RUN);
        end
    end

    // Next state: clear beats start_stop
    always_comb begin
        w_next = r_state;
        if (w_clr_ev) begin
            w_next = IDLE;
        end else if (w_ss_ev) begin
            case (r_state)
                IDLE:    w_next = RUN;
                RUN:     w_next = PAUSE;
                PAUSE:   w_next = RUN;
                default: w_next = IDLE;
            endcase
        end
    end

    // Prescaler counts only in RUN and holds in PAUSE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_clr_ev || w_tick) begin
            r_presc <= '0;
        end else if (r_state == RUN) begin
            r_presc <= r_presc + PW'(1);
        end
    end

    bcd_digit_cnt u_d0 (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr_ev), .i_inc(w_tick),
        .i_max(BCD_MAX), .o_digit(w_d0), .o_carry(w_c0)
    );
    bcd_digit_cnt u_d1 (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr_ev), .i_inc(w_c0),
        .i_max(BCD_MAX), .o_digit(w_d1), .o_carry(w_c1)
    );
    bcd_digit_cnt u_d2 (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr_ev), .i_inc(w_c1),
        .i_max(BCD_MAX), .o_digit(w_d2), .o_carry(w_c2)
    );
    bcd_digit_cnt u_d3 (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr_ev), .i_inc(w_c2),
        .i_max(D3_MAX), .o_digit(w_d3), .o_carry(w_c3)
    );

    // Wrap pulse when the top decade rolls over to 00.00
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_c3 && !w_clr_ev;
        end
    end

    assign bus.running = r_running;
    assign bus.wrap    = r_wrap;

`ifdef STOPWATCH_LAP_EN
    logic r_lap_q;
    logic r_lap_active;
    logic [15:0] r_frz;
    logic w_lap_ev;

    assign w_lap_ev = bus.lap & ~r_lap_q;

    // Lap toggles a display freeze while the live count keeps running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lap_q      <= 1'b1;
            r_lap_active <= 1'b0;
            r_frz        <= '0;
        end else begin
            r_lap_q <= bus.lap;
            if (w_clr_ev) begin
                r_lap_active <= 1'b0;
            end else if (w_lap_ev && (r_state == RUN)) begin
                r_lap_active <= ~r_lap_active;
                if (!r_lap_active) begin
                    r_frz <= {w_d3, w_d2, w_d1, w_d0};
                end
            end
        end
    end

    assign bus.lap_active = r_lap_active;
    assign bus.dig0 = r_lap_active ? r_frz[3:0]   : w_d0;
    assign bus.dig1 = r_lap_active ? r_frz[7:4]   : w_d1;
    assign bus.dig2 = r_lap_active ? r_frz[11:8]  : w_d2;
    assign bus.dig3 = r_lap_active ? r_frz[15:12] : w_d3;
`else
    assign bus.dig0 = w_d0;
    assign bus.dig1 = w_d1;
    assign bus.dig2 = w_d2;
    assign bus.dig3 = w_d3;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed bench with a centisecond-level model.
// Define STOPWATCH_LAP_EN to also exercise the lap freeze.
module tb_stopwatch_counter;

    localparam int CLK_DIV   = 4;
    localparam int SEC_LIMIT = 60;
    localparam int MODULUS   = SEC_LIMIT * 100;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic chk_en = 1'b0;
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stopwatch_counter_if u_if();

    stopwatch_counter #(
        .CLK_DIV(CLK_DIV),
        .SEC_LIMIT(SEC_LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(u_if)
    );

    logic lap_in;
    logic lap_act;
`ifdef STOPWATCH_LAP_EN
    assign lap_in  = u_if.lap;
    assign lap_act = u_if.lap_active;
`else
    assign lap_in  = 1'b0;
    assign lap_act = 1'b0;
`endif

    logic [15:0] dd;
    assign dd = {u_if.dig3, u_if.dig2, u_if.dig1, u_if.dig0};

    // Model: state 0 idle, 1 run, 2 pause; cs = total centiseconds
    typedef struct {
        int st;
        int sub;
        int cs;
        bit wrap;
        bit lap;
        int frz;
        bit ssq;
        bit clq;
        bit lpq;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t m_reset();
        mdl_t r;
        r.st = 0; r.sub = 0; r.cs = 0; r.wrap = 0;
        r.lap = 0; r.frz = 0; r.ssq = 1; r.clq = 1; r.lpq = 1;
        return r;
    endfunction

    function automatic mdl_t m_step(mdl_t c, bit ss, bit cl, bit lp);
        mdl_t n;
        bit sse, cle, lpe;
        n = c;
        sse = ss && !c.ssq;
        cle = cl && !c.clq;
        lpe = lp && !c.lpq;
        n.wrap = 0;
        if (cle) begin
            n.st = 0; n.sub = 0; n.cs = 0; n.lap = 0;
        end else begin
            if (c.st == 1) begin
                if (c.sub == CLK_DIV - 1) begin
                    n.sub = 0;
                    n.cs = c.cs + 1;
                    if (n.cs == MODULUS) begin
                        n.cs = 0;
                        n.wrap = 1;
                    end
                end else begin
                    n.sub = c.sub + 1;
                end
                if (lpe) begin
                    if (c.lap) n.lap = 0;
                    else begin
                        n.lap = 1;
                        n.frz = c.cs;
                    end
                end
            end
            if (sse) n.st = (c.st == 1) ? 2 : 1;
        end
        n.ssq = ss; n.clq = cl; n.lpq = lp;
        return n;
    endfunction

    function automatic int m_disp(mdl_t c);
        return c.lap ? c.frz : c.cs;
    endfunction

    function automatic logic [18:0] m_expect(mdl_t c);
        int d;
        d = m_disp(c);
        return {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10),
                4'(d % 10), (c.st == 1), c.wrap, c.lap};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= m_reset();
        else m <= m_step(m, u_if.start_stop, u_if.clear, lap_in);
    end

    // Every-cycle comparison of DUT against the model
    always @(negedge clk) begin
        if (chk_en) begin
            n_chk++;
            if ({dd, u_if.running, u_if.wrap, lap_act} !== m_expect(m)) begin
                n_err++;
                $display("FAIL cycle t=%0t: got %h need %h", $time,
                         {dd, u_if.running, u_if.wrap, lap_act}, m_expect(m));
            end
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h need %h", nm, got, exp);
        end
    endtask

    task automatic wait_disp(int tgt, int budget);
        int k;
        k = 0;
        while (m_disp(m) != tgt && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_target", 32'(m_disp(m)), 32'(tgt));
    endtask

    task automatic press_ss();
        u_if.start_stop = 1'b1;
        @(negedge clk);
        u_if.start_stop = 1'b0;
    endtask

    task automatic press_clr();
        u_if.clear = 1'b1;
        @(negedge clk);
        u_if.clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wraps;
        u_if.start_stop = 1'b0;
        u_if.clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
        u_if.lap = 1'b0;
`endif
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        #2;
        chk("reset_digits", 32'(dd), 32'h0000);
        chk("reset_running", 32'(u_if.running), 32'd0);
        chk("reset_wrap", 32'(u_if.wrap), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // start, held 10 cycles, then pause 2 cycles after 00.03
        u_if.start_stop = 1'b1;
        repeat (10) @(negedge clk);
        u_if.start_stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("run_0003", 32'(dd), 32'h0003);
        chk("run_running", 32'(u_if.running), 32'd1);
        @(negedge clk);
        press_ss();
        chk("pause_running", 32'(u_if.running), 32'd0);
        chk("pause_digits", 32'(dd), 32'h0003);
        repeat (50) @(negedge clk);
        press_ss();
        chk("resume_running", 32'(u_if.running), 32'd1);
        chk("resume_r0", 32'(dd), 32'h0003);
        @(negedge clk);
        chk("resume_r1", 32'(dd), 32'h0003);
        @(negedge clk);
        chk("resume_0004", 32'(dd), 32'h0004);

        // clear, then 40 clocks of run gives 00.10
        press_clr();
        chk("clear_digits", 32'(dd), 32'h0000);
        chk("clear_running", 32'(u_if.running), 32'd0);
        u_if.start_stop = 1'b1;
        repeat (10) @(negedge clk);
        u_if.start_stop = 1'b0;
        repeat (31) @(negedge clk);
        chk("run_0010", 32'(dd), 32'h0010);
        chk("run_0010_running", 32'(u_if.running), 32'd1);

        // clear and start_stop together while paused at 03.21
        wait_disp(321, 2000);
        press_ss();
        chk("pause_0321", 32'(dd), 32'h0321);
        repeat (3) @(negedge clk);
        u_if.start_stop = 1'b1;
        u_if.clear = 1'b1;
        @(negedge clk);
        u_if.start_stop = 1'b0;
        u_if.clear = 1'b0;
        chk("both_digits", 32'(dd), 32'h0000);
        chk("both_running", 32'(u_if.running), 32'd0);
        repeat (3) @(negedge clk);
        chk("both_idle", 32'(u_if.running), 32'd0);

        // asynchronous reset mid-run at 12.34
        press_ss();
        wait_disp(1234, 6000);
        chk("pre_reset_1234", 32'(dd), 32'h1234);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_digits", 32'(dd), 32'h0000);
        chk("async_running", 32'(u_if.running), 32'd0);
        chk("async_wrap", 32'(u_if.wrap), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 6000 ticks from 00.00 wrap exactly once
        wraps = 0;
        u_if.start_stop = 1'b1;
        for (int i = 1; i <= MODULUS * CLK_DIV + 1; i++) begin
            @(negedge clk);
            if (i == 1) u_if.start_stop = 1'b0;
            if (u_if.wrap) wraps++;
            if (i == MODULUS * CLK_DIV)
                chk("max_5999", 32'(dd), 32'h5999);
        end
        chk("wrap_count", 32'(wraps), 32'd1);
        chk("wrap_pulse", 32'(u_if.wrap), 32'd1);
        chk("wrap_digits", 32'(dd), 32'h0000);
        chk("wrap_running", 32'(u_if.running), 32'd1);

`ifdef STOPWATCH_LAP_EN
        press_clr();
        press_ss();
        wait_disp(50, 1000);
        u_if.lap = 1'b1;
        @(negedge clk);
        u_if.lap = 1'b0;
        chk("lap_on", 32'(u_if.lap_active), 32'd1);
        repeat (399) @(negedge clk);
        chk("lap_hold", 32'(dd), 32'h0050);
        chk("lap_hold_act", 32'(u_if.lap_active), 32'd1);
        u_if.lap = 1'b1;
        @(negedge clk);
        u_if.lap = 1'b0;
        chk("lap_release", 32'(dd), 32'h0150);
        chk("lap_off", 32'(u_if.lap_active), 32'd0);
`endif

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
